// File: rtl/test_detector_sequencer.sv
// Test-pulse run controller: fires a train of test pulses, ORs the hit bus over a
// coincidence window after each pulse and streams one result word per pulse.
module test_detector_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int CNTR_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  cfg_start,
    input  logic [CNTR_WIDTH-1:0] cfg_runs,
    input  logic [7:0]            cfg_window,
    input  logic [CNTR_WIDTH-1:0] cfg_period,
    output logic                  pulse,
    output logic                  busy,
    output logic                  done,
    output logic [CNTR_WIDTH-1:0] run_cntr,
    output logic [CNTR_WIDTH-1:0] miss_cntr,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    typedef enum logic [2:0] {IDLE, PULSE, WINDOW, SEND, GAP} state_t;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

    state_t                state;
    logic                  start_q;
    logic                  start_prev;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [CNTR_WIDTH-1:0] runs_l;
    logic [CNTR_WIDTH-1:0] period_l;
    logic [CNTR_WIDTH-1:0] pcnt;
    logic [7:0]            window_l;
    logic [7:0]            wcnt;
    logic                  start_edge;
    logic                  last_run;
    logic                  stall;

    assign start_edge = start_q & ~start_prev;
    assign last_run   = (run_cntr == runs_l - CNT_ONE);
    assign stall      = (state == SEND) & ~m_axis_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            start_q       <= 1'b0;
            start_prev    <= 1'b0;
            din_q         <= '0;
            acc           <= '0;
            runs_l        <= '0;
            period_l      <= '0;
            window_l      <= '0;
            pcnt          <= '0;
            wcnt          <= '0;
            pulse         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            run_cntr      <= '0;
            miss_cntr     <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            start_q    <= cfg_start;
            start_prev <= start_q;
            din_q      <= din;

            // Stalled cycles do not count toward the period, so backpressure
            // pushes the next pulse back by exactly the stall length.
            if (pcnt != '1 && !stall) begin
                pcnt <= pcnt + CNT_ONE;
            end

            case (state)
                IDLE: begin
                    if (start_edge && cfg_runs != '0) begin
                        runs_l    <= cfg_runs;
                        window_l  <= cfg_window;
                        period_l  <= cfg_period;
                        run_cntr  <= '0;
                        miss_cntr <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        pulse     <= 1'b1;
                        pcnt      <= CNT_ONE;
                        state     <= PULSE;
                    end
                end

                PULSE: begin
                    pulse <= 1'b0;
                    acc   <= '0;
                    wcnt  <= '0;
                    state <= WINDOW;
                end

                // din_q lags din by one edge, so the window covers din sampled
                // at the edges starting right after the pulse cycle.
                WINDOW: begin
                    acc <= acc | din_q;
                    if (wcnt == window_l) begin
                        m_axis_tdata  <= acc | din_q;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= last_run;
                        state         <= SEND;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end

                SEND: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        run_cntr      <= run_cntr + CNT_ONE;
                        if (m_axis_tdata == '0) begin
                            miss_cntr <= miss_cntr + CNT_ONE;
                        end
                        if (m_axis_tlast) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (pcnt >= period_l) begin
                        pulse <= 1'b1;
                        pcnt  <= CNT_ONE;
                        state <= PULSE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_detector_sequencer.sv
// Bench for test_detector_sequencer: directed scenarios plus randomized runs,
// checked against a cycle-indexed hit history and per-sequence expectations.
module tb_test_detector_sequencer;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] din = '0;
    logic          cfg_start = 1'b0;
    logic [CW-1:0] cfg_runs = '0;
    logic [7:0]    cfg_window = '0;
    logic [CW-1:0] cfg_period = '0;
    logic          pulse;
    logic          busy;
    logic          done;
    logic [CW-1:0] run_cntr;
    logic [CW-1:0] miss_cntr;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;

    test_detector_sequencer #(.DATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .din          (din),
        .cfg_start    (cfg_start),
        .cfg_runs     (cfg_runs),
        .cfg_window   (cfg_window),
        .cfg_period   (cfg_period),
        .pulse        (pulse),
        .busy         (busy),
        .done         (done),
        .run_cntr     (run_cntr),
        .miss_cntr    (miss_cntr),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // expectations for the sequence in flight
    int  exp_runs = 0, exp_w = 0, exp_period = 0;
    bit  mon_en = 1'b0;
    // monitor bookkeeping
    int  n_pulses = 0, n_words = 0, n_zero = 0, total_pulses = 0;
    int  last_pulse = 0, stall_cnt = 0, prev_stall = 0, done_due = -1;
    bit  prev_tvalid = 1'b0;
    logic [DW-1:0] held = '0, cur_exp = '0, last_word = '0;
    logic          held_last = 1'b0;
    // stimulus controls
    logic [DW-1:0] din_hist [int];
    logic [DW-1:0] din_in = '0, din_out = '0;
    bit  din_rand = 1'b0;
    int  drv_win = -1000;
    int  rdy_mode = 0;
    int  stall_left = 0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got no summary, required one");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // din and tready driven just after each rising edge; din history kept per cycle
    always @(posedge aclk) begin
        #1;
        if (pulse) drv_win = cyc;
        if (din_rand)
            din = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '0;
        else
            din = (cyc >= drv_win && cyc <= drv_win + exp_w) ? din_in : din_out;
        din_hist[cyc] = din;
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = 1'($urandom_range(0, 1));
            2: begin
                if (m_axis_tvalid && stall_left > 0) begin
                    m_axis_tready = 1'b0;
                    stall_left--;
                end else begin
                    m_axis_tready = 1'b1;
                end
            end
            default: m_axis_tready = 1'b0;
        endcase
    end

    // reference monitor: expected word = OR of din over the window cycles after each pulse
    always @(negedge aclk) begin
        if (pulse) total_pulses++;
        if (mon_en) begin
            if (pulse) begin
                chk("pulse_busy", 64'(busy), 64'(1));
                chk("pulse_done", 64'(done), 64'(0));
                if (n_pulses > 0)
                    chk("pulse_interval", 64'(cyc - last_pulse),
                        64'(imax(exp_period, exp_w + 4) + prev_stall));
                last_pulse = cyc;
                n_pulses++;
            end
            if (m_axis_tvalid) begin
                if (!prev_tvalid) begin
                    chk("tvalid_latency", 64'(cyc - last_pulse), 64'(exp_w + 2));
                    cur_exp = '0;
                    for (int k = last_pulse; k <= last_pulse + exp_w; k++)
                        cur_exp |= din_hist[k];
                    chk("tdata", m_axis_tdata, cur_exp);
                    chk("tlast", 64'(m_axis_tlast), 64'(n_words == exp_runs - 1));
                    held      = m_axis_tdata;
                    held_last = m_axis_tlast;
                end else begin
                    chk("tdata_hold", m_axis_tdata, held);
                    chk("tlast_hold", 64'(m_axis_tlast), 64'(held_last));
                end
                if (m_axis_tready) begin
                    chk("run_cntr_mid", 64'(run_cntr), 64'(n_words));
                    n_words++;
                    if (cur_exp == '0) n_zero++;
                    prev_stall = stall_cnt;
                    stall_cnt  = 0;
                    last_word  = m_axis_tdata;
                    if (n_words == exp_runs) done_due = cyc + 1;
                end else begin
                    stall_cnt++;
                end
            end
            if (cyc == done_due) begin
                chk("done_set", 64'(done), 64'(1));
                chk("busy_fall", 64'(busy), 64'(0));
                chk("run_cntr_end", 64'(run_cntr), 64'(exp_runs));
                chk("miss_cntr_end", 64'(miss_cntr), 64'(n_zero));
            end
            prev_tvalid = m_axis_tvalid && !m_axis_tready;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic start_seq(input int runs, input int w, input int period);
        n_pulses = 0; n_words = 0; n_zero = 0; stall_cnt = 0; prev_stall = 0;
        done_due = -1; prev_tvalid = 1'b0;
        exp_runs = runs; exp_w = w; exp_period = period; drv_win = -1000;
        cfg_runs = CW'(runs); cfg_window = 8'(w); cfg_period = CW'(period);
        mon_en = 1'b1;
        cfg_start = 1'b1;
        tick(2);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        chk({tag, "_done_in_time"}, 64'(done), 64'(1));
        @(negedge aclk);
        chk({tag, "_pulses"}, 64'(n_pulses), 64'(exp_runs));
        chk({tag, "_words"}, 64'(n_words), 64'(exp_runs));
        mon_en = 1'b0;
        tick(1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_pulse"}, 64'(pulse), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_run_cntr"}, 64'(run_cntr), 64'(0));
        chk({tag, "_miss_cntr"}, 64'(miss_cntr), 64'(0));
        chk({tag, "_tdata"}, m_axis_tdata, 64'(0));
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'(0));
        chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'(0));
    endtask

    initial begin
        int n;
        int p0;
        tick(3);
        chk_outputs_zero("reset");
        aresetn = 1'b1;
        tick(2);

        // single run, single-channel hit inside the window
        rdy_mode = 0; din_rand = 0; din_in = 64'h1; din_out = '0;
        start_seq(1, 3, 0);
        wait_done("t1", 200);
        chk("t1_word", last_word, 64'h1);

        // four empty runs at a fixed period
        din_in = '0;
        start_seq(4, 0, 20);
        wait_done("t2", 400);
        chk("t2_miss", 64'(miss_cntr), 64'(4));

        // backpressure on the first word
        rdy_mode = 2; stall_left = 10; din_rand = 1;
        start_seq(2, 2, 20);
        wait_done("t3", 400);
        rdy_mode = 0;

        // hits outside the window are discarded
        din_rand = 0; din_in = 64'h8000_0000_0000_0001; din_out = 64'hFFFF_0000_0000_0000;
        start_seq(1, 5, 0);
        wait_done("t4", 200);
        chk("t4_word", last_word, 64'h8000_0000_0000_0001);
        din_out = '0;

        // zero-run start is ignored
        p0 = total_pulses;
        cfg_runs = '0; cfg_start = 1'b1;
        tick(2);
        cfg_start = 1'b0;
        tick(20);
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_pulses", 64'(total_pulses - p0), 64'(0));

        // mid-sequence start edge and config change have no effect
        din_rand = 1;
        start_seq(3, 2, 12);
        tick(3);
        cfg_window = 8'd9; cfg_runs = CW'(1); cfg_period = '0;
        cfg_start = 1'b1;
        tick(2);
        cfg_start = 1'b0;
        wait_done("t6", 400);

        // randomized sequences with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) begin
            start_seq(int'($urandom_range(1, 5)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 40)));
            wait_done("rnd", 3000);
        end
        rdy_mode = 0;

        // reset during WINDOW
        start_seq(2, 10, 0);
        mon_en = 1'b0;
        n = 0;
        while (pulse !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        chk("rst_win_pulse_seen", 64'(pulse), 64'(1));
        tick(3);
        aresetn = 1'b0;
        tick(1);
        chk_outputs_zero("rst_window");
        aresetn = 1'b1;
        tick(2);

        // reset during a stalled SEND
        rdy_mode = 3;
        start_seq(1, 1, 0);
        mon_en = 1'b0;
        n = 0;
        while (m_axis_tvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        chk("rst_send_tvalid_seen", 64'(m_axis_tvalid), 64'(1));
        tick(2);
        chk("rst_send_stalled", 64'(m_axis_tvalid), 64'(1));
        aresetn = 1'b0;
        tick(1);
        chk_outputs_zero("rst_send");
        aresetn = 1'b1;
        rdy_mode = 0;
        tick(2);

        // normal run after reset
        start_seq(2, 3, 10);
        wait_done("post_rst", 400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
